// File: rtl/fifo_ddr_wr_burst.sv
// fifo_ddr_wr_burst: drains 256-bit words from the prefetch FIFO read port into
// the DDR frame buffer as fixed-length AXI4 INCR write bursts. Burst addresses
// advance linearly through one frame and restart at BASE_ADDR on frame end or
// on a frame_start request.
module fifo_ddr_wr_burst #(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned ADDR_WIDTH  = 28,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FRAME_BEATS = 129600,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    fifo_rd_vld,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic                    fifo_rd_en,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wlast,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic                    axi_bvalid,
    input  logic [1:0]              axi_bresp,
    output logic                    axi_bready,
    output logic                    frame_done,
    output logic                    bresp_err
);

    localparam int unsigned BT_W = $clog2(FRAME_BEATS + 1);
    localparam int unsigned BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [BC_W-1:0]       LAST_BEAT  = BC_W'(BURST_LEN - 1);
    localparam logic [BT_W-1:0]       LAST_TOTAL = BT_W'(FRAME_BEATS - BURST_LEN);
    localparam logic [BT_W-1:0]       BEAT_STEP  = BT_W'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } state_t;

    state_t                  state_q, state_d;
    logic                    awvalid_q, awvalid_d;
    logic                    bready_q, bready_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BC_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [BT_W-1:0]         beat_total_q, beat_total_d;
    logic                    pend_fs_q, pend_fs_d;
    logic                    frame_done_q, frame_done_d;
    logic                    bresp_err_q, bresp_err_d;

    logic                    w_hs;
    logic                    frame_end;

    // Zero-latency FIFO-to-W data path and constant burst attributes
    assign axi_wvalid  = (state_q == ST_W) && fifo_rd_vld;
    assign axi_wdata   = fifo_rd_data;
    assign axi_wstrb   = '1;
    assign axi_wlast   = (state_q == ST_W) && (beat_cnt_q == LAST_BEAT);
    assign axi_awlen   = 8'(BURST_LEN - 1);
    assign w_hs        = axi_wvalid && axi_wready;
    assign fifo_rd_en  = w_hs;

    assign axi_awaddr  = addr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_bready  = bready_q;
    assign frame_done  = frame_done_q;
    assign bresp_err   = bresp_err_q;

    // The burst now in flight is the last one of the frame
    assign frame_end   = (beat_total_q == LAST_TOTAL);

    // Next-state logic: burst sequencing, address/frame bookkeeping, status flags
    always_comb begin
        state_d      = state_q;
        awvalid_d    = awvalid_q;
        bready_d     = bready_q;
        addr_d       = addr_q;
        beat_cnt_d   = beat_cnt_q;
        beat_total_d = beat_total_q;
        pend_fs_d    = pend_fs_q;
        frame_done_d = 1'b0;
        bresp_err_d  = bresp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    addr_d       = BASE_ADDR;
                    beat_total_d = '0;
                end
                if (fifo_rd_vld) begin
                    state_d   = ST_AW;
                    awvalid_d = 1'b1;
                end
            end
            ST_AW: begin
                if (frame_start) pend_fs_d = 1'b1;
                if (axi_awready) begin
                    awvalid_d  = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                if (frame_start) pend_fs_d = 1'b1;
                if (w_hs) begin
                    if (axi_wlast) begin
                        beat_cnt_d = '0;
                        bready_d   = 1'b1;
                        state_d    = ST_B;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_B: begin
                if (frame_start) pend_fs_d = 1'b1;
                if (axi_bvalid) begin
                    if (axi_bresp != 2'b00) bresp_err_d = 1'b1;
                    // A restart request arriving on the handshake cycle merges
                    // with any pending one and with the frame-end wrap.
                    if (pend_fs_q || frame_start || frame_end) begin
                        addr_d       = BASE_ADDR;
                        beat_total_d = '0;
                    end else begin
                        addr_d       = addr_q + ADDR_STEP;
                        beat_total_d = beat_total_q + BEAT_STEP;
                    end
                    frame_done_d = frame_end;
                    pend_fs_d    = 1'b0;
                    bready_d     = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered-output flops with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            awvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            addr_q       <= BASE_ADDR;
            beat_cnt_q   <= '0;
            beat_total_q <= '0;
            pend_fs_q    <= 1'b0;
            frame_done_q <= 1'b0;
            bresp_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            awvalid_q    <= awvalid_d;
            bready_q     <= bready_d;
            addr_q       <= addr_d;
            beat_cnt_q   <= beat_cnt_d;
            beat_total_q <= beat_total_d;
            pend_fs_q    <= pend_fs_d;
            frame_done_q <= frame_done_d;
            bresp_err_q  <= bresp_err_d;
        end
    end

endmodule
